i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx_pkg.sv | 13 +
 rtl/i2s_clk_gen.sv | 40 ++++
 rtl/i2s_tx.sv | 94 +++++++++
 tb/tb_i2s_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_pkg.sv
// Shared I2S framing defaults, used by the transmitter and the sine sample source.
package i2s_tx_pkg;

  localparam int unsigned BCLK_DIV_DEF = 4;
  localparam int unsigned SAMPLE_W_DEF = 24;
  localparam int unsigned SLOT_W_DEF   = 32;

  // Word select for a frame position: right channel starts one BCLK before its MSB.
  function automatic logic lrclk_for_pos(input int unsigned pos, input int unsigned slot_w);
    return (pos >= slot_w - 1) && (pos <= 2 * slot_w - 2);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider: bclk toggles every BCLK_DIV clk cycles; bclk_fall marks the cycle whose
// closing edge drives bclk low, so framing logic can update in step with the fall.
module i2s_clk_gen
  import i2s_tx_pkg::*;
#(
  parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic bclk_fall
);

  localparam int unsigned CNT_W = $clog2(BCLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;
  logic             pre_wrap_c;

  always_comb begin
    wrap_c     = (cnt == CNT_W'(BCLK_DIV - 1));
    pre_wrap_c = (cnt == CNT_W'(BCLK_DIV - 2));
  end

  // bclk_fall is registered one cycle early so it lines up with the wrap that drops bclk.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bclk      <= 1'b0;
      bclk_fall <= 1'b0;
    end else begin
      cnt       <= wrap_c ? '0 : cnt + CNT_W'(1);
      bclk_fall <= pre_wrap_c && bclk;
      if (wrap_c) begin
        bclk <= ~bclk;
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry sample buffer, frame position counter and MSB-first shifter;
// each accepted mono sample is sent in both the left and right slots.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned BCLK_DIV = BCLK_DIV_DEF,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned SLOT_W   = SLOT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun
);

  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned POS_W   = $clog2(FRAME_W);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_W - 1);
  localparam logic [POS_W-1:0] POS_RIGHT = POS_W'(SLOT_W);

  logic                bclk_fall;
  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    pos_next_c;
  logic [SAMPLE_W-1:0] buf_data;
  logic [SAMPLE_W-1:0] held;
  logic [SAMPLE_W-1:0] shifter;
  logic [SAMPLE_W-1:0] load_val_c;
  logic                buf_full;
  logic                buf_full_next_c;
  logic                accept_c;
  logic                frame_start_c;

  i2s_clk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .bclk      (bclk),
    .bclk_fall (bclk_fall)
  );

  always_comb begin
    pos_next_c      = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    frame_start_c   = bclk_fall && (pos == POS_LAST);
    accept_c        = in_valid && in_ready;
    load_val_c      = buf_full ? buf_data : '0;
    // A sample accepted on the frame-load cycle waits for the next frame.
    buf_full_next_c = (buf_full && !frame_start_c) || accept_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos      <= POS_LAST;
      buf_data <= '0;
      buf_full <= 1'b0;
      held     <= '0;
      shifter  <= '0;
      in_ready <= 1'b1;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      buf_full <= buf_full_next_c;
      in_ready <= !buf_full_next_c;
      if (accept_c) begin
        buf_data <= in_data;
      end
      if (bclk_fall) begin
        pos   <= pos_next_c;
        lrclk <= lrclk_for_pos(32'(pos_next_c), SLOT_W);
        // Zero-fill shifting leaves sdata low once the sample bits are exhausted.
        if (frame_start_c) begin
          held     <= load_val_c;
          sdata    <= load_val_c[SAMPLE_W-1];
          shifter  <= load_val_c << 1;
          underrun <= !buf_full;
        end else if (pos_next_c == POS_RIGHT) begin
          sdata   <= held[SAMPLE_W-1];
          shifter <= held << 1;
        end else begin
          sdata   <= shifter[SAMPLE_W-1];
          shifter <= shifter << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at BCLK_DIV=2, SAMPLE_W=24, SLOT_W=32 (frame = 256 clk).
module tb_i2s_tx;

  localparam int unsigned BCLK_DIV = 2;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned SLOT_W   = 32;

  logic                clk      = 1'b0;
  logic                reset    = 1'b1;
  logic                in_valid = 1'b0;
  logic [SAMPLE_W-1:0] in_data  = '0;
  logic                in_ready;
  logic                bclk;
  logic                lrclk;
  logic                sdata;
  logic                underrun;

  i2s_tx #(
    .BCLK_DIV (BCLK_DIV),
    .SAMPLE_W (SAMPLE_W),
    .SLOT_W   (SLOT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state, cleared while reset is high
  int          cyc;
  bit          mon_valid;
  logic        b_prev, lr_prev, sd_prev;
  int          rise_t, lr_rise_t;
  logic        dec_lr;
  logic [31:0] dec_sh;
  logic [31:0] dec_q[$];
  logic [23:0] acc_q[$];
  int          ur_count, ur_first, ur_last;
  int          hs_n, hs_last;
  int          rdy_low_n, sd_high_n;
  bit          pend_rdy;
  bit          stream_mode = 1'b0;
  bit          idle_mode   = 1'b0;

  // Waveform monitor and I2S receiver: samples sdata on bclk rise, emits a 32-bit slot
  // word at each lrclk transition (the transition bit closes the previous slot).
  initial forever begin
    @(negedge clk);
    if (reset) begin
      cyc = 0; mon_valid = 0; rise_t = -1; lr_rise_t = -1;
      dec_lr = 1'b0; dec_sh = '0; dec_q.delete(); acc_q.delete();
      ur_count = 0; ur_first = -1; ur_last = -1; hs_n = 0; hs_last = -1;
      rdy_low_n = 0; sd_high_n = 0; pend_rdy = 0;
    end else begin
      if (pend_rdy) check("ready_low_after_accept", 32'(in_ready), 32'd0);
      pend_rdy = 0;
      if (!in_ready) rdy_low_n++;
      if (sdata) sd_high_n++;
      if (mon_valid) begin
        if (sdata !== sd_prev || lrclk !== lr_prev)
          check("change_on_bclk_fall", 32'(b_prev && !bclk), 32'd1);
        if (!b_prev && bclk) begin
          if (rise_t >= 0) check("bclk_period", 32'(cyc - rise_t), 32'd4);
          rise_t = cyc;
          dec_sh = {dec_sh[30:0], sdata};
          if (lrclk !== dec_lr) dec_q.push_back(dec_sh);
          dec_lr = lrclk;
        end
        if (!lr_prev && lrclk) begin
          if (lr_rise_t >= 0) check("lrclk_period", 32'(cyc - lr_rise_t), 32'd256);
          lr_rise_t = cyc;
        end
        if (lr_prev && !lrclk && lr_rise_t >= 0)
          check("lrclk_high", 32'(cyc - lr_rise_t), 32'd128);
      end
      if (underrun) begin
        if (idle_mode && ur_last >= 0) check("underrun_interval", 32'(cyc - ur_last), 32'd256);
        if (ur_first < 0) ur_first = cyc;
        ur_last = cyc;
        ur_count++;
      end
      if (in_valid && in_ready) begin
        acc_q.push_back(in_data);
        hs_n++;
        if (stream_mode && hs_n >= 3) check("handshake_interval", 32'(cyc - hs_last), 32'd256);
        hs_last  = cyc;
        pend_rdy = 1;
      end
      b_prev = bclk; lr_prev = lrclk; sd_prev = sdata;
      mon_valid = 1;
      cyc++;
    end
  end

  // Called and returns at posedge+1; holds data until the handshake edge.
  task automatic send(input logic [23:0] d);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles, required 1", waited);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [23:0] sample;
    logic [31:0] slot_word;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] nz_q[$];
  int nz;

  initial begin
    vecs[0] = '{24'hABCDEF, 32'hABCDEF00};
    vecs[1] = '{24'h800000, 32'h80000000};
    vecs[2] = '{24'h7FFFFF, 32'h7FFFFF00};
    vecs[3] = '{24'h000001, 32'h00000100};
    vecs[4] = '{24'hFFFFFF, 32'hFFFFFF00};
    vecs[5] = '{24'h5A5A5A, 32'h5A5A5A00};

    // Reset values
    do_reset();
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lrclk", 32'(lrclk), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Idle: zeros, one underrun per frame, first at 4 clk after release
    idle_mode = 1'b1;
    run(780);
    check("idle_first_underrun", 32'(ur_first), 32'd4);
    check("idle_underrun_count", 32'(ur_count), 32'd4);
    check("idle_sdata_high", 32'(sd_high_n), 32'd0);
    check("idle_ready_low", 32'(rdy_low_n), 32'd0);
    idle_mode = 1'b0;

    // Table stream, valid from reset release
    do_reset();
    stream_mode = 1'b1;
    for (int i = 0; i < 6; i++) send(vecs[i].sample);
    check("stream_underrun", 32'(ur_count), 32'd0);
    run(600);
    stream_mode = 1'b0;
    check("stream_accepts", 32'(acc_q.size()), 32'd6);
    check("stream_words_ge12", 32'(dec_q.size() >= 12), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (dec_q.size() >= 2 * i + 2) begin
        check($sformatf("stream_left[%0d]", i), dec_q[2*i], vecs[i].slot_word);
        check($sformatf("stream_right[%0d]", i), dec_q[2*i+1], vecs[i].slot_word);
      end
    end

    // Reset at pos 10 with a sample buffered: sample must be discarded
    do_reset();
    send(24'h111111);
    send(24'h222222);
    repeat (39) @(posedge clk);
    #1;
    check("pre_reset_buffer_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_bclk", 32'(bclk), 32'd0);
    check("midrst_lrclk", 32'(lrclk), 32'd0);
    check("midrst_sdata", 32'(sdata), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("underrun_in_reset", 32'(underrun), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_mode = 1'b1;
    run(600);
    idle_mode = 1'b0;
    nz = 0;
    foreach (dec_q[i]) if (dec_q[i] != 32'd0) nz++;
    check("post_reset_words_ge4", 32'(dec_q.size() >= 4), 32'd1);
    check("post_reset_nonzero_words", 32'(nz), 32'd0);
    check("post_reset_underruns", 32'(ur_count), 32'd3);

    // Random arrival times; scoreboard accepted samples against received slots
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run($urandom_range(0, 300));
      send(24'($urandom) | 24'h000001);
    end
    run(800);
    nz_q.delete();
    foreach (dec_q[i]) if (dec_q[i] != 32'd0) nz_q.push_back(dec_q[i]);
    check("rand_accepts", 32'(acc_q.size()), 32'd12);
    check("rand_word_count", 32'(nz_q.size()), 32'(2 * acc_q.size()));
    for (int i = 0; i < acc_q.size(); i++) begin
      if (nz_q.size() >= 2 * i + 2) begin
        check($sformatf("rand_left[%0d]", i), nz_q[2*i], {acc_q[i], 8'h00});
        check($sformatf("rand_right[%0d]", i), nz_q[2*i+1], {acc_q[i], 8'h00});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, test incomplete");
    $fatal(1, "watchdog");
  end

endmodule
